meas_delay_stim: RTL and testbench

Clocked stimulus generator, the drive end of delay measurement: on command it emits a launch edge on `out1` and, a programmed number of clock cycles later, a capture edge on `out2`. Bursts of such edge pairs repeat at a programmed period. It sits in testbenches and calibration loops upstream of `meas_delay`, whose `in1`/`in2` it drives with matching polarity parameters, so a known delay can be checked against the measured one.

---
 rtl/meas_delay_stim_pkg.sv | 23 ++
 rtl/meas_delay_stim_phase.sv | 24 ++
 rtl/meas_delay_stim.sv | 118 +++++++++++
 tb/tb_meas_delay_stim.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/meas_delay_stim_pkg.sv
// Shared types and helpers for the meas_delay_stim edge-pair generator.
package meas_delay_stim_pkg;

  localparam int EXT_W = 33;
  typedef logic [EXT_W-1:0] ext_t;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_FIN  = 2'd2;

  // Clamp the period so the out2 pulse of one pair ends before the next out1 edge.
  function automatic ext_t eff_period(input ext_t delay, input ext_t period, input ext_t pw);
    ext_t need;
    need = delay + pw + ext_t'(1);
    return (period > need) ? period : need;
  endfunction

  function automatic logic idle_lvl(input logic dir);
    return ~dir;
  endfunction

endpackage

// File: rtl/meas_delay_stim_phase.sv
// Window decode of the phase counter: raw (polarity-free) active flags for out1/out2.
module meas_delay_stim_phase #(
  parameter int CW      = 16,
  parameter int PULSE_W = 2
) (
  input  logic [CW:0]   cnt,
  input  logic [CW-1:0] delay_cyc,
  output logic          act1,
  output logic          act2
);

  localparam logic [CW:0] PW = (CW+1)'(PULSE_W);

  logic [CW:0] d_ext;
  logic [CW:0] d_end;

  // CW+1 bits so delay + PULSE_W never wraps.
  assign d_ext = {1'b0, delay_cyc};
  assign d_end = d_ext + PW;

  assign act1 = (cnt < PW);
  assign act2 = (cnt >= d_ext) && (cnt < d_end);

endmodule

// File: rtl/meas_delay_stim.sv
// Launch/capture edge-pair burst generator driving a downstream delay meter.
// state | meaning
// IDLE  | ready, waiting for start
// RUN   | emitting edge pairs, cnt is the phase within the current period
// FIN   | one-cycle done pulse, outputs inactive
module meas_delay_stim
  import meas_delay_stim_pkg::*;
#(
  parameter logic out1_dir = 1'b1,
  parameter logic out2_dir = 1'b1,
  parameter int   CW       = 16,
  parameter int   NW       = 8,
  parameter int   PULSE_W  = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          ready,
  input  logic [CW-1:0] delay_cyc,
  input  logic [CW-1:0] period_cyc,
  input  logic [NW-1:0] count,
  output logic          out1,
  output logic          out2,
  output logic          busy,
  output logic          done,
  output logic [NW-1:0] pair_idx
);

  localparam logic [CW:0] ONE_C = (CW+1)'(1);

  state_t        state_q, state_nxt;
  logic [CW:0]   cnt_q, cnt_nxt, eff_q;
  logic [CW-1:0] delay_q, delay_sel;
  logic [NW-1:0] count_q, pair_q, pair_nxt;
  logic          ready_q, busy_q, done_q, out1_q, out2_q;
  logic          accept, act1, act2, run_nxt;
  ext_t          eff_full;
  logic          unused_eff_hi;

  assign accept    = start && ready_q;
  assign eff_full  = eff_period(ext_t'(delay_cyc), ext_t'(period_cyc), ext_t'(PULSE_W));
  assign unused_eff_hi = ^eff_full[EXT_W-1:CW+1];
  // Outputs are registered from the next phase, so the accept cycle must decode the raw input.
  assign delay_sel = accept ? delay_cyc : delay_q;

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    pair_nxt  = pair_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cnt_nxt   = '0;
          pair_nxt  = '0;
          state_nxt = (count == '0) ? ST_FIN : ST_RUN;
        end
      end
      ST_RUN: begin
        if (cnt_q == eff_q - ONE_C) begin
          cnt_nxt = '0;
          if (pair_q == count_q - NW'(1)) state_nxt = ST_FIN;
          else pair_nxt = pair_q + NW'(1);
        end else begin
          cnt_nxt = cnt_q + ONE_C;
        end
      end
      ST_FIN:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  meas_delay_stim_phase #(.CW(CW), .PULSE_W(PULSE_W)) u_phase (
    .cnt       (cnt_nxt),
    .delay_cyc (delay_sel),
    .act1      (act1),
    .act2      (act2)
  );

  assign run_nxt = (state_nxt == ST_RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      eff_q   <= '0;
      delay_q <= '0;
      count_q <= '0;
      pair_q  <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      out1_q  <= idle_lvl(out1_dir);
      out2_q  <= idle_lvl(out2_dir);
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      pair_q  <= pair_nxt;
      if (accept) begin
        delay_q <= delay_cyc;
        count_q <= count;
        eff_q   <= eff_full[CW:0];
      end
      ready_q <= (state_nxt == ST_IDLE);
      busy_q  <= (state_nxt != ST_IDLE);
      done_q  <= (state_nxt == ST_FIN);
      out1_q  <= (run_nxt && act1) ? out1_dir : idle_lvl(out1_dir);
      out2_q  <= (run_nxt && act2) ? out2_dir : idle_lvl(out2_dir);
    end
  end

  assign ready    = ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign out1     = out1_q;
  assign out2     = out2_q;
  assign pair_idx = pair_q;

endmodule

// File: tb/tb_meas_delay_stim.sv
// Randomized bench for meas_delay_stim: two polarity variants checked against a cycle-indexed burst model.
module tb_meas_delay_stim;

  localparam int PW = 2;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [15:0] delay_cyc, period_cyc;
  logic [7:0]  count;
  logic        rdy[2], o1[2], o2[2], bsy[2], dn[2];
  logic [7:0]  pidx[2];
  logic [1:0]  dir1, dir2;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  meas_delay_stim #(.out1_dir(1'b1), .out2_dir(1'b1), .CW(16), .NW(8), .PULSE_W(PW)) dut_a (
    .clk(clk), .rst(rst), .start(start), .ready(rdy[0]),
    .delay_cyc(delay_cyc), .period_cyc(period_cyc), .count(count),
    .out1(o1[0]), .out2(o2[0]), .busy(bsy[0]), .done(dn[0]), .pair_idx(pidx[0])
  );

  meas_delay_stim #(.out1_dir(1'b1), .out2_dir(1'b0), .CW(16), .NW(8), .PULSE_W(PW)) dut_b (
    .clk(clk), .rst(rst), .start(start), .ready(rdy[1]),
    .delay_cyc(delay_cyc), .period_cyc(period_cyc), .count(count),
    .out1(o1[1]), .out2(o2[1]), .busy(bsy[1]), .done(dn[1]), .pair_idx(pidx[1])
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accepts one burst, then checks every cycle from T+1 up to the ready cycle
  // (or up to abort_at). rel = cycle - (T+1).
  task automatic drive_burst(input int d, input int p, input int n, input bit hold, input int abort_at);
    int eff, last, k, ph;
    bit in_run, e1, e2, edone, erdy;
    eff  = (p > d + PW + 1) ? p : d + PW + 1;
    last = n * eff + 1;
    delay_cyc  = 16'(d);
    period_cyc = 16'(p);
    count      = 8'(n);
    start      = 1'b1;
    step();
    for (int rel = 0; rel <= last; rel++) begin
      start = hold;
      if (hold) begin
        delay_cyc  = 16'($urandom);
        period_cyc = 16'($urandom);
        count      = 8'($urandom);
      end
      k      = rel / eff;
      ph     = rel % eff;
      in_run = (k < n);
      e1     = in_run && (ph < PW);
      e2     = in_run && (ph >= d) && (ph < d + PW);
      edone  = (rel == n * eff);
      erdy   = (rel > n * eff);
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (o1[i] !== (e1 ? dir1[i] : ~dir1[i])) begin
          miscompares++;
          $display("FAIL out1 dut%0d d=%0d p=%0d n=%0d rel=%0d got=%b exp_active=%b", i, d, p, n, rel, o1[i], e1);
        end
        vectors++;
        if (o2[i] !== (e2 ? dir2[i] : ~dir2[i])) begin
          miscompares++;
          $display("FAIL out2 dut%0d d=%0d p=%0d n=%0d rel=%0d got=%b exp_active=%b", i, d, p, n, rel, o2[i], e2);
        end
        vectors++;
        if (dn[i] !== edone) begin
          miscompares++;
          $display("FAIL done dut%0d d=%0d p=%0d n=%0d rel=%0d got=%b exp=%b", i, d, p, n, rel, dn[i], edone);
        end
        vectors++;
        if (rdy[i] !== erdy) begin
          miscompares++;
          $display("FAIL ready dut%0d d=%0d p=%0d n=%0d rel=%0d got=%b exp=%b", i, d, p, n, rel, rdy[i], erdy);
        end
        if (in_run) begin
          vectors++;
          if (bsy[i] !== 1'b1) begin
            miscompares++;
            $display("FAIL busy dut%0d rel=%0d got=%b exp=1", i, rel, bsy[i]);
          end
          vectors++;
          if (pidx[i] !== 8'(k)) begin
            miscompares++;
            $display("FAIL pair_idx dut%0d rel=%0d got=%0d exp=%0d", i, rel, pidx[i], k);
          end
        end else if (erdy) begin
          vectors++;
          if (bsy[i] !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_idle dut%0d rel=%0d got=%b exp=0", i, rel, bsy[i]);
          end
        end
      end
      if (rel == abort_at) break;
      if (rel < last) step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    delay_cyc = '0;
    period_cyc = '0;
    count = '0;
    step();
    step();
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (rdy[i] !== 1'b1 || bsy[i] !== 1'b0 || dn[i] !== 1'b0 || pidx[i] !== 8'd0) begin
        miscompares++;
        $display("FAIL reset_ctrl dut%0d got rdy=%b bsy=%b dn=%b pidx=%0d exp 1 0 0 0", i, rdy[i], bsy[i], dn[i], pidx[i]);
      end
      vectors++;
      if (o1[i] !== ~dir1[i] || o2[i] !== ~dir2[i]) begin
        miscompares++;
        $display("FAIL reset_out dut%0d got o1=%b o2=%b exp o1=%b o2=%b", i, o1[i], o2[i], ~dir1[i], ~dir2[i]);
      end
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    drive_burst(5, 20, 3, 1'b0, -1);
  endtask

  task automatic test_zero_delay();
    drive_burst(0, int'($urandom_range(0, 6)), 1, 1'b0, -1);
  endtask

  task automatic test_clamp();
    drive_burst(10, 4, 2, 1'b0, -1);
  endtask

  task automatic test_count_zero();
    drive_burst(int'($urandom_range(0, 9)), int'($urandom_range(0, 30)), 0, 1'b0, -1);
  endtask

  task automatic test_random();
    for (int j = 0; j < 6; j++)
      drive_burst(int'($urandom_range(0, 30)), int'($urandom_range(0, 40)),
                  int'($urandom_range(1, 4)), 1'b0, -1);
  endtask

  task automatic test_back_to_back();
    drive_burst(3, 9, 2, 1'b1, -1);
    drive_burst(int'($urandom_range(0, 8)), int'($urandom_range(0, 12)), 2, 1'b1, -1);
    drive_burst(1, 0, 1, 1'b0, -1);
  endtask

  task automatic test_count_max();
    drive_burst(0, 0, 255, 1'b0, -1);
  endtask

  task automatic test_reset_mid();
    drive_burst(5, 20, 3, 1'b0, 25);
    rst = 1'b1;
    step();
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (rdy[i] !== 1'b1 || bsy[i] !== 1'b0 || dn[i] !== 1'b0 || pidx[i] !== 8'd0 ||
          o1[i] !== ~dir1[i] || o2[i] !== ~dir2[i]) begin
        miscompares++;
        $display("FAIL reset_mid dut%0d got rdy=%b bsy=%b dn=%b pidx=%0d o1=%b o2=%b", i, rdy[i], bsy[i], dn[i], pidx[i], o1[i], o2[i]);
      end
    end
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (dn[i] !== 1'b0 || rdy[i] !== 1'b1 || o1[i] !== ~dir1[i] || o2[i] !== ~dir2[i]) begin
          miscompares++;
          $display("FAIL after_reset dut%0d c=%0d got dn=%b rdy=%b o1=%b o2=%b", i, c, dn[i], rdy[i], o1[i], o2[i]);
        end
      end
    end
    drive_burst(5, 20, 3, 1'b0, -1);
  endtask

  initial begin
    dir1 = 2'b11;
    dir2 = 2'b01;
    test_reset();
    test_basic();
    test_zero_delay();
    test_clamp();
    test_count_zero();
    test_random();
    test_back_to_back();
    test_count_max();
    test_reset_mid();
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
